// File: rtl/xfer_pkg.sv
// Shared types and defaults for the transfer scheduler: FSM state encoding,
// default channel count / word width and the timeout counter width.
package xfer_pkg;

    localparam int unsigned N_CH_DEF   = 4;
    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned TMO_CNT_W  = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    typedef enum logic [1:0] {
        XS_IDLE  = ST_IDLE,
        XS_GRANT = ST_GRANT,
        XS_SEND  = ST_SEND
    } xfer_state_e;

    // Channel index width, never below one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last
// grant and the first set request bit wins.
module rr_arbiter
    import xfer_pkg::*;
#(
    parameter  int unsigned N_CH  = N_CH_DEF,
    localparam int unsigned IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [N_CH-1:0]  gnt_c,
    output logic [IDX_W-1:0] idx_c
);

    int ch_c;

    // Walk offsets from farthest to nearest so the nearest set bit is written last
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        ch_c  = 0;
        for (int off = int'(N_CH); off >= 1; off--) begin
            ch_c = (int'(last) + off) % int'(N_CH);
            if (req[IDX_W'(ch_c)]) begin
                gnt_c                = '0;
                gnt_c[IDX_W'(ch_c)]  = 1'b1;
                idx_c                = IDX_W'(ch_c);
            end
        end
    end

endmodule

// File: rtl/xfer_scheduler.sv
// Multi-channel scheduler feeding one serial transfer engine (IDLE/GRANT/SEND).
// Optional macro XFER_SCHED_URGENT_EN: channel 0 overrides round-robin.
module xfer_scheduler
    import xfer_pkg::*;
#(
    parameter  int unsigned N_CH    = N_CH_DEF,
    parameter  int unsigned WORD_W  = WORD_W_DEF,
    parameter  int unsigned TIMEOUT = 1024,
    localparam int unsigned IDX_W   = idx_w(N_CH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_CH-1:0]        i_req,
    input  logic [N_CH*WORD_W-1:0] i_data,
    output logic [N_CH-1:0]        o_ack,
    output logic [WORD_W-1:0]      o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_err,
    output logic [IDX_W-1:0]       o_grant_id
);

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]      ack_d;
    logic [WORD_W-1:0]    data_d;
    logic                 valid_d, busy_d, err_d;
    logic [IDX_W-1:0]     gid_d;

    logic [N_CH-1:0]      rr_gnt_c, win_onehot_c;
    logic [IDX_W-1:0]     rr_idx_c, win_idx_c;
    logic                 urgent_c;
    logic [WORD_W-1:0]    words [N_CH];

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_words
        assign words[g] = i_data[g*WORD_W +: WORD_W];
    end

    rr_arbiter #(.N_CH(N_CH)) u_rr (
        .req   (i_req),
        .last  (last_q),
        .gnt_c (rr_gnt_c),
        .idx_c (rr_idx_c)
    );

`ifdef XFER_SCHED_URGENT_EN
    assign urgent_c = i_req[0];
`else
    assign urgent_c = 1'b0;
`endif

    assign win_onehot_c = urgent_c ? N_CH'(1) : rr_gnt_c;
    assign win_idx_c    = urgent_c ? '0 : rr_idx_c;

    // Next state and next registered outputs; o_tx_valid rises with o_ack so
    // the engine first samples it one edge after the grant edge.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        data_d  = o_tx_data;
        valid_d = o_tx_valid;
        err_d   = o_err;
        gid_d   = o_grant_id;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (|i_req) begin
                    ack_d   = win_onehot_c;
                    data_d  = words[win_idx_c];
                    gid_d   = win_idx_c;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                    if (!urgent_c) last_d = win_idx_c;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (i_tx_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_CNT_W'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= IDX_W'(N_CH - 1);
            cnt_q      <= '0;
            o_ack      <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_grant_id <= IDX_W'(N_CH - 1);
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            o_ack      <= ack_d;
            o_tx_data  <= data_d;
            o_tx_valid <= valid_d;
            o_busy     <= busy_d;
            o_err      <= err_d;
            o_grant_id <= gid_d;
        end
    end

endmodule

// File: tb/tb_xfer_scheduler.sv
// Self-checking bench for xfer_scheduler with a transaction-level reference
// model (rotated-request round-robin, sticky error, fixed grant latency).
module tb_xfer_scheduler;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TMO    = 8;
    localparam logic [127:0] COMMON = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
`ifdef XFER_SCHED_URGENT_EN
    localparam bit URGENT = 1'b1;
`else
    localparam bit URGENT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   ack;
    logic [31:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         err;
    logic [1:0]   gid;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last;
    bit m_err;

    always #5 clk = ~clk;

    xfer_scheduler #(.N_CH(N_CH), .WORD_W(WORD_W), .TIMEOUT(TMO)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_data     (data),
        .o_ack      (ack),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_err      (err),
        .o_grant_id (gid)
    );

    // Reference winner: rotate so bit j stands for channel (last+1+j) mod 4
    function automatic int rr_pick(input logic [3:0] r, input int last);
        logic [7:0] dbl;
        if (URGENT && r[0]) return 0;
        dbl = {r, r} >> (last + 1);
        for (int j = 0; j < 4; j++)
            if (dbl[j]) return (last + 1 + j) % 4;
        return -1;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] v, input int ch);
        return v[ch*32 +: 32];
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        tx_ready = 1'b0;
        data     = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        @(negedge clk);
        m_last = 3;
        m_err  = 1'b0;
    endtask

    // Raise a request from IDLE, return cycles until o_ack is seen; request then drops
    task automatic launch(input logic [3:0] r, output int lat);
        req = r;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack === 4'b0000 && lat < 10);
        req = '0;
    endtask

    // Hold ready low for d SEND cycles then high; count cycles with valid high
    task automatic run_send(input int d, output int cycles, output bit held);
        logic [31:0] first;
        first  = tx_data;
        cycles = 0;
        held   = 1'b1;
        while (tx_valid === 1'b1 && cycles < 20) begin
            cycles++;
            tx_ready = (cycles > d);
            data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_data !== first) held = 1'b0;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (gid !== 2'd3) begin n_fail++; $display("FAIL reset_gid: got %0d want 3", gid); end
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        data     = COMMON;
        tx_ready = 1'b1;
        launch(4'b0100, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", lat); end
        n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", ack); end
        n_checks++; if (tx_data !== 32'hBBBBBBBB) begin n_fail++; $display("FAIL single_data: got %h want BBBBBBBB", tx_data); end
        n_checks++; if (gid !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d want 2", gid); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", tx_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", busy); end
        tx_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int cyc = 0;
        int n = 0;
        int prev = 0;
        int ch;
        do_reset();
        data     = COMMON;
        tx_ready = 1'b1;
        req      = 4'b1111;
        while (n < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            n_checks++; if (!$onehot0(ack)) begin n_fail++; $display("FAIL rr_onehot: got %b want one-hot or zero", ack); end
            if (ack !== 4'b0000) begin
                ch = $clog2(ack);
                n_checks++; if (ch !== n % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", n, ch, n % 4); end
                n_checks++; if (tx_data !== word_of(COMMON, n % 4)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", n, tx_data, word_of(COMMON, n % 4)); end
                if (n > 0) begin
                    n_checks++; if (cyc - prev !== 3) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want 3", n, cyc - prev); end
                end
                prev = cyc;
                n++;
            end
        end
        n_checks++; if (n !== 5) begin n_fail++; $display("FAIL rr_count: got %0d want 5", n); end
        req = '0;
        repeat (4) @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic test_dropped_req();
        bit seen = 1'b0;
        int lat;
        do_reset();
        data = COMMON;
        req  = 4'b0010;
        @(negedge clk);
        req = '0;
        repeat (6) begin
            @(negedge clk);
            if (ack !== 4'b0000) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL drop_no_ack: got %b want 0", seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b want 0", busy); end
        tx_ready = 1'b1;
        launch(4'b1111, lat);
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL drop_next_grant: got %b want 0001", ack); end
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int lat, cycles;
        bit held;
        do_reset();
        data = COMMON;
        launch(4'b0001, lat);
        run_send(TMO - 1, cycles, held);
        n_checks++; if (cycles !== int'(TMO)) begin n_fail++; $display("FAIL tmo_edge_cycles: got %0d want %0d", cycles, TMO); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_err: got %b want 0", err); end
        launch(4'b0001, lat);
        run_send(1000, cycles, held);
        n_checks++; if (cycles !== int'(TMO)) begin n_fail++; $display("FAIL tmo_cycles: got %0d want %0d", cycles, TMO); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_valid: got %b want 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got %b want 0", busy); end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL tmo_hold: got %b want 1", held); end
        launch(4'b0001, lat);
        run_send(0, cycles, held);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_send();
        int lat;
        do_reset();
        data = COMMON;
        launch(4'b0100, lat);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_checks++; if (gid !== 2'd3) begin n_fail++; $display("FAIL rst_mid_gid: got %0d want 3", gid); end
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        launch(4'b0101, lat);
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_next: got %b want 0001", ack); end
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic test_urgent();
        int cyc = 0;
        int n = 0;
        int want;
        do_reset();
        data     = COMMON;
        tx_ready = 1'b1;
        req      = 4'b1001;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ack !== 4'b0000) begin
                want = URGENT ? 0 : ((n % 2 == 0) ? 0 : 3);
                n_checks++; if ($clog2(ack) !== want) begin n_fail++; $display("FAIL urgent_order[%0d]: got %0d want %0d", n, $clog2(ack), want); end
                n++;
            end
        end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL urgent_count: got %0d want 4", n); end
        req = '0;
        repeat (4) @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]   r;
        logic [127:0] snap;
        int exp_ch, lat, d, cycles, exp_cycles;
        bit held, seen;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            r = 4'($urandom_range(0, 15));
            if (r == 4'b0000) begin
                seen = 1'b0;
                req  = r;
                repeat (4) begin
                    @(negedge clk);
                    if (ack !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
                end
                n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rand_idle[%0d]: got activity want none", it); end
                continue;
            end
            snap     = {$urandom, $urandom, $urandom, $urandom};
            data     = snap;
            tx_ready = 1'b0;
            d        = $urandom_range(0, 10);
            exp_ch   = rr_pick(r, m_last);
            launch(r, lat);
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 2", it, lat); end
            n_checks++; if (ack !== 4'(1 << exp_ch)) begin n_fail++; $display("FAIL rand_ack[%0d]: got %b want %b (req %b)", it, ack, 4'(1 << exp_ch), r); end
            n_checks++; if (tx_data !== word_of(snap, exp_ch)) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", it, tx_data, word_of(snap, exp_ch)); end
            n_checks++; if (gid !== 2'(exp_ch)) begin n_fail++; $display("FAIL rand_gid[%0d]: got %0d want %0d", it, gid, exp_ch); end
            if (!(URGENT && r[0])) m_last = exp_ch;
            run_send(d, cycles, held);
            exp_cycles = (d >= int'(TMO)) ? int'(TMO) : d + 1;
            if (d >= int'(TMO)) m_err = 1'b1;
            n_checks++; if (cycles !== exp_cycles) begin n_fail++; $display("FAIL rand_send_len[%0d]: got %0d want %0d", it, cycles, exp_cycles); end
            n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL rand_hold[%0d]: got %b want 1", it, held); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want %b", it, err, m_err); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle_after[%0d]: got %b want 0", it, busy); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        data     = '0;
        tx_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_dropped_req();
        test_timeout();
        test_reset_mid_send();
        test_urgent();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xfer_scheduler.md
XFER_SCHEDULER -- requirements
Module: xfer_scheduler

Interface
REQ-001 Parameter N_CH, default 4, number of requesting channels sharing one serial transfer engine.
REQ-002 Parameter WORD_W, default 32, width of each channel word.
REQ-003 Parameter TIMEOUT, default 1024, cycles o_tx_valid may stay high without i_tx_ready before the word is dropped.
REQ-004 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  N_CH  per-channel word-available level.
REQ-007 i_data  in  N_CH*WORD_W  channel i word at bits [WORD_W*i +: WORD_W].
REQ-008 o_ack  out  N_CH  one-cycle pulse to the granted channel when its word is consumed.
REQ-009 o_tx_data  out  WORD_W  word presented to the transfer engine.
REQ-010 o_tx_valid  out  1  o_tx_data is valid.
REQ-011 i_tx_ready  in  1  engine accepts o_tx_data on a cycle with o_tx_valid=1.
REQ-012 o_busy  out  1  high in any state other than IDLE.
REQ-013 o_err  out  1  sticky timeout flag.
REQ-014 o_grant_id  out  clog2(N_CH)  index of the last granted channel.

Function
REQ-015 FSM states: IDLE, GRANT, SEND.
- IDLE: when any i_req bit is 1 -> GRANT.
- GRANT: winner latched; o_tx_data loaded; o_ack[winner] pulsed; -> SEND.
- SEND: o_tx_valid=1; on i_tx_ready=1 -> IDLE.
REQ-016 Arbitration is round-robin: the search starts at (last_grant+1) mod N_CH; the first set i_req bit wins.
REQ-017 Latency: i_req sampled high at edge k; o_ack and the o_tx_data load occur at edge k+1; o_tx_valid is high from edge k+2.
REQ-018 o_tx_data holds the word latched in GRANT; it does not follow i_data changes during SEND.
REQ-019 Handshake: a transfer occurs on a cycle with o_tx_valid=1 and i_tx_ready=1; o_tx_valid falls at the next edge.
REQ-020 Minimum spacing between consecutive grants is 3 cycles (IDLE, GRANT, SEND); back-to-back requests never skip IDLE.
REQ-021 A request deasserted before GRANT is ignored; if no i_req bit is set in GRANT, the FSM returns to IDLE with no o_ack.
REQ-022 The timeout counter counts cycles in SEND with i_tx_ready=0; on reaching TIMEOUT: o_err <= 1, o_tx_valid drops, FSM -> IDLE; the counter clears on every SEND entry.
REQ-023 If i_tx_ready=1 occurs on the same cycle the counter reaches TIMEOUT, the transfer completes and o_err is unchanged.
REQ-024 last_grant wraps from N_CH-1 to 0.
REQ-025 o_ack is one-hot or zero in every cycle.

Reset
REQ-026 Asserting i_rst_n=0 forces, asynchronously: state=IDLE, o_ack=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_err=0, o_grant_id=N_CH-1 (so channel 0 is searched first), and clears the timeout counter.
REQ-027 Reset during SEND abandons the word; that channel is not re-acked.

Configuration
REQ-028 Macro XFER_SCHED_URGENT_EN:
- Defined: channel 0 wins whenever its i_req is set, overriding round-robin; last_grant is not updated by urgent grants.
- Undefined: pure round-robin per REQ-016.

Structure
REQ-029 A shared package xfer_pkg holds the FSM state enum, the default WORD_W/N_CH constants, and the timeout counter width.
REQ-030 The round-robin picker is a sub-module, rr_arbiter: request vector plus last grant in, one-hot winner and index out; purely combinational.

Verification
Common stimulus for REQ-031 to REQ-034: i_data=128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD.
REQ-031 i_req=4'b0100, i_tx_ready=1 -> o_ack=4'b0100 for 1 cycle, o_tx_data=32'hBBBBBBBB, o_grant_id=2.
REQ-032 i_req=4'b1111 held, i_tx_ready=1 -> grant order 0,1,2,3,0, one grant per 3 cycles; data DDDDDDDD, CCCCCCCC, BBBBBBBB, AAAAAAAA.
REQ-033 i_req=4'b0001, i_tx_ready=0 with TIMEOUT=8 -> o_err=1 after 8 SEND cycles, o_tx_valid=0, FSM back in IDLE.
REQ-034 i_rst_n pulsed low mid-SEND -> all outputs at reset values immediately; the next grant is channel 0.
REQ-035 With XFER_SCHED_URGENT_EN: i_req=4'b1001 held -> every grant is channel 0; without the macro, grants alternate 0,3.
